// File: rtl/fb_draw_scheduler.sv
// Command queue and pixel sequencer feeding the framebuffer write port.
// Expands PLOT/HLINE/VLINE/CLEAR into one clipped pixel write per granted cycle.
module fb_draw_scheduler #(
    parameter int unsigned FB_W         = 200,
    parameter int unsigned FB_H         = 150,
    parameter int unsigned FIFO_DEPTH   = 4,
    parameter bit          STALL_ACTIVE = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       reg_we,
    input  logic [1:0] reg_addr,
    input  logic [7:0] reg_data,
    input  logic       scan_active,
    output logic       fb_we,
    output logic [7:0] fb_x,
    output logic [7:0] fb_y,
    output logic [2:0] fb_color,
    output logic       busy,
    output logic       overflow
);

    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned CUR_W = 9;
    localparam int unsigned REM_W = $clog2(FB_W * FB_H);

    localparam logic [1:0] OP_PLOT  = 2'b00;
    localparam logic [1:0] OP_HLINE = 2'b01;
    localparam logic [1:0] OP_VLINE = 2'b10;
    localparam logic [1:0] OP_CLEAR = 2'b11;

    typedef struct packed {
        logic [1:0] op;
        logic [5:0] len;
        logic [7:0] x;
        logic [7:0] y;
        logic [2:0] color;
    } cmd_t;

    typedef enum logic {IDLE, DRAW} state_t;

    state_t             state, state_next;
    logic [7:0]         sh_x, sh_y;
    logic [2:0]         sh_color;
    cmd_t               mem [FIFO_DEPTH];
    cmd_t               head;
    logic [PTR_W-1:0]   wr_ptr, rd_ptr;
    logic [CNT_W-1:0]   count, count_next;
    logic               full, empty, push_req, push, pop;
    logic [CUR_W-1:0]   cx, cy, cx_next, cy_next;
    logic [REM_W-1:0]   rem, rem_next;
    logic [2:0]         ccol, ccol_next;
    logic [1:0]         cop, cop_next;
    logic               grant, in_range, fb_we_next;

    // Fullness is judged on the pre-pop count, so a push while full drops even if a pop happens.
    assign push_req   = reg_we && (reg_addr == 2'd3);
    assign full       = (count == CNT_W'(FIFO_DEPTH));
    assign empty      = (count == '0);
    assign push       = push_req && !full;
    assign head       = mem[rd_ptr];
    assign count_next = count + CNT_W'(push) - CNT_W'(pop);

    assign grant    = !scan_active || !STALL_ACTIVE;
    assign in_range = (cx < CUR_W'(FB_W)) && (cy < CUR_W'(FB_H));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sh_x     <= '0;
            sh_y     <= '0;
            sh_color <= '0;
        end else if (reg_we) begin
            case (reg_addr)
                2'd0:    sh_x     <= reg_data;
                2'd1:    sh_y     <= reg_data;
                2'd2:    sh_color <= reg_data[2:0];
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= '{op: reg_data[7:6], len: reg_data[5:0],
                             x: sh_x, y: sh_y, color: sh_color};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count_next;
            if (push_req && full) overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        cx_next    = cx;
        cy_next    = cy;
        rem_next   = rem;
        ccol_next  = ccol;
        cop_next   = cop;
        fb_we_next = 1'b0;
        pop        = 1'b0;
        case (state)
            IDLE: begin
                if (!empty) begin
                    pop        = 1'b1;
                    cop_next   = head.op;
                    ccol_next  = head.color;
                    state_next = DRAW;
                    if (head.op == OP_CLEAR) begin
                        cx_next  = '0;
                        cy_next  = '0;
                        rem_next = REM_W'(FB_W * FB_H - 1);
                    end else begin
                        cx_next  = {1'b0, head.x};
                        cy_next  = {1'b0, head.y};
                        rem_next = (head.op == OP_PLOT) ? '0 : REM_W'(head.len);
                    end
                end
            end
            DRAW: begin
                // Without a grant the cursor holds, so the stalled pixel is retried unchanged.
                if (grant) begin
                    fb_we_next = in_range;
                    if (rem == '0 || !in_range) begin
                        state_next = IDLE;
                    end else begin
                        rem_next = rem - REM_W'(1);
                        case (cop)
                            OP_HLINE: cx_next = cx + CUR_W'(1);
                            OP_VLINE: cy_next = cy + CUR_W'(1);
                            OP_CLEAR: begin
                                if (cx == CUR_W'(FB_W - 1)) begin
                                    cx_next = '0;
                                    cy_next = cy + CUR_W'(1);
                                end else begin
                                    cx_next = cx + CUR_W'(1);
                                end
                            end
                            default: ;
                        endcase
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cx       <= '0;
            cy       <= '0;
            rem      <= '0;
            ccol     <= '0;
            cop      <= OP_PLOT;
            fb_we    <= 1'b0;
            fb_x     <= '0;
            fb_y     <= '0;
            fb_color <= '0;
            busy     <= 1'b0;
        end else begin
            cx    <= cx_next;
            cy    <= cy_next;
            rem   <= rem_next;
            ccol  <= ccol_next;
            cop   <= cop_next;
            fb_we <= fb_we_next;
            if (fb_we_next) begin
                fb_x     <= cx[7:0];
                fb_y     <= cy[7:0];
                fb_color <= ccol;
            end
            busy <= (count_next != '0) || (state_next != IDLE);
        end
    end

endmodule

// File: tb/tb_fb_draw_scheduler.sv
// Directed bench for fb_draw_scheduler: vector table plus multi-cycle sequences.
module tb_fb_draw_scheduler;

    logic       clk = 1'b0;
    logic       rst;
    logic       reg_we;
    logic [1:0] reg_addr;
    logic [7:0] reg_data;
    logic       scan_active;
    logic       fb_we;
    logic [7:0] fb_x, fb_y;
    logic [2:0] fb_color;
    logic       busy, overflow;

    int checks = 0;
    int errors = 0;

    fb_draw_scheduler dut (
        .clk(clk), .rst(rst), .reg_we(reg_we), .reg_addr(reg_addr),
        .reg_data(reg_data), .scan_active(scan_active), .fb_we(fb_we),
        .fb_x(fb_x), .fb_y(fb_y), .fb_color(fb_color), .busy(busy),
        .overflow(overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       we;
        logic [1:0] addr;
        logic [7:0] data;
        logic       scan;
        logic       ewe;
        logic [7:0] ex;
        logic [7:0] ey;
        logic [2:0] ec;
        logic       ebusy;
    } vec_t;

    vec_t vecs[$];

    // Write log: {x, y, color} of every pixel, plus writes whose deciding cycle had scan high.
    logic [18:0] wq[$];
    logic        dec_scan = 1'b0;
    int          viol = 0;

    always @(posedge clk) dec_scan <= scan_active;
    always @(negedge clk) begin
        if (!rst && fb_we) begin
            wq.push_back({fb_x, fb_y, fb_color});
            if (dec_scan) viol++;
        end
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic add(input logic we, input logic [1:0] addr, input logic [7:0] data,
                       input logic scan, input logic ewe, input logic [7:0] ex,
                       input logic [7:0] ey, input logic [2:0] ec, input logic ebusy);
        vec_t v;
        v.we = we; v.addr = addr; v.data = data; v.scan = scan;
        v.ewe = ewe; v.ex = ex; v.ey = ey; v.ec = ec; v.ebusy = ebusy;
        vecs.push_back(v);
    endtask

    task automatic step(input logic we, input logic [1:0] addr, input logic [7:0] data,
                        input logic scan);
        reg_we = we; reg_addr = addr; reg_data = data; scan_active = scan;
        @(posedge clk);
        #1;
        reg_we = 1'b0;
    endtask

    task automatic drain(input int limit, input logic scan);
        int cyc = 0;
        while (busy && cyc < limit) begin
            step(1'b0, 2'd0, 8'd0, scan);
            cyc++;
        end
        check("drain_timeout", int'(busy), 0);
        step(1'b0, 2'd0, 8'd0, scan);
    endtask

    initial begin
        int cyc;
        int bad;
        rst = 1'b1; reg_we = 1'b0; reg_addr = '0; reg_data = '0; scan_active = 1'b0;

        // PLOT (10,20,5): write lands 3 edges after the CMD strobe.
        add(1, 2'd0, 8'd10, 0, 0, 0, 0, 0, 0);
        add(1, 2'd1, 8'd20, 0, 0, 0, 0, 0, 0);
        add(1, 2'd2, 8'd5,  0, 0, 0, 0, 0, 0);
        add(1, 2'd3, 8'h00, 0, 0, 0, 0, 0, 1);
        add(0, 2'd0, 8'd0,  0, 0, 0, 0, 0, 1);
        add(0, 2'd0, 8'd0,  0, 1, 8'd10, 8'd20, 3'd5, 0);
        add(0, 2'd0, 8'd0,  0, 0, 0, 0, 0, 0);
        // HLINE from x=195 len 9 clips after x=199.
        add(1, 2'd0, 8'd195, 0, 0, 0, 0, 0, 0);
        add(1, 2'd1, 8'd5,   0, 0, 0, 0, 0, 0);
        add(1, 2'd3, 8'h49,  0, 0, 0, 0, 0, 1);
        add(0, 2'd0, 8'd0,   0, 0, 0, 0, 0, 1);
        for (int k = 0; k < 5; k++) add(0, 2'd0, 8'd0, 0, 1, 8'(195 + k), 8'd5, 3'd5, 1);
        add(0, 2'd0, 8'd0,   0, 0, 0, 0, 0, 0);
        // VLINE from y=145 len 15 clips after y=149.
        add(1, 2'd0, 8'd100, 0, 0, 0, 0, 0, 0);
        add(1, 2'd1, 8'd145, 0, 0, 0, 0, 0, 0);
        add(1, 2'd3, 8'h8F,  0, 0, 0, 0, 0, 1);
        add(0, 2'd0, 8'd0,   0, 0, 0, 0, 0, 1);
        for (int k = 0; k < 5; k++) add(0, 2'd0, 8'd0, 0, 1, 8'd100, 8'(145 + k), 3'd5, 1);
        add(0, 2'd0, 8'd0,   0, 0, 0, 0, 0, 0);
        // PLOT at x=200 is consumed with no write.
        add(1, 2'd0, 8'd200, 0, 0, 0, 0, 0, 0);
        add(1, 2'd3, 8'h00,  0, 0, 0, 0, 0, 1);
        add(0, 2'd0, 8'd0,   0, 0, 0, 0, 0, 1);
        add(0, 2'd0, 8'd0,   0, 0, 0, 0, 0, 0);
        add(0, 2'd0, 8'd0,   0, 0, 0, 0, 0, 0);

        #12;
        check("rst_fb_we", int'(fb_we), 0);
        check("rst_fb_x", int'(fb_x), 0);
        check("rst_fb_y", int'(fb_y), 0);
        check("rst_fb_color", int'(fb_color), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_overflow", int'(overflow), 0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        foreach (vecs[i]) begin
            step(vecs[i].we, vecs[i].addr, vecs[i].data, vecs[i].scan);
            check($sformatf("vec%0d_we", i), int'(fb_we), int'(vecs[i].ewe));
            check($sformatf("vec%0d_busy", i), int'(busy), int'(vecs[i].ebusy));
            if (vecs[i].ewe) begin
                check($sformatf("vec%0d_x", i), int'(fb_x), int'(vecs[i].ex));
                check($sformatf("vec%0d_y", i), int'(fb_y), int'(vecs[i].ey));
                check($sformatf("vec%0d_color", i), int'(fb_color), int'(vecs[i].ec));
            end
        end
        check("table_overflow", int'(overflow), 0);

        // CLEAR with scan toggling every cycle: full raster, no write in a scan cycle.
        wq.delete(); viol = 0;
        step(1, 2'd2, 8'd3, 0);
        step(1, 2'd3, 8'hC0, 0);
        cyc = 0;
        while (busy && cyc < 70000) begin
            step(0, 2'd0, 8'd0, logic'(cyc % 2));
            cyc++;
        end
        check("clear_timeout", int'(busy), 0);
        step(0, 2'd0, 8'd0, 0);
        check("clear_count", wq.size(), 30000);
        bad = 0;
        foreach (wq[i]) if (wq[i] !== {8'(i % 200), 8'(i / 200), 3'd3}) bad++;
        check("clear_raster_order", bad, 0);
        check("clear_scan_viol", viol, 0);

        // Stalled queue: first CMD sits in the FSM, next four fill the FIFO, sixth overflows.
        wq.delete(); viol = 0;
        step(1, 2'd1, 8'd7, 1);
        for (int k = 0; k < 6; k++) begin
            step(1, 2'd0, 8'(k + 1), 1);
            step(1, 2'd3, 8'h00, 1);
            if (k == 4) check("ovf_before_full_push", int'(overflow), 0);
        end
        check("ovf_set", int'(overflow), 1);
        check("stall_no_writes", wq.size(), 0);
        check("stall_busy", int'(busy), 1);
        drain(100, 0);
        check("ovf_write_count", wq.size(), 5);
        bad = 0;
        foreach (wq[i]) if (wq[i] !== {8'(i + 1), 8'd7, 3'd3}) bad++;
        check("ovf_order", bad, 0);
        check("ovf_sticky", int'(overflow), 1);

        // Async reset between edges during CLEAR.
        step(1, 2'd3, 8'hC0, 0);
        for (int k = 0; k < 20; k++) step(0, 2'd0, 8'd0, 0);
        check("pre_rst_fb_we", int'(fb_we), 1);
        #2 rst = 1'b1;
        #1;
        check("midrst_fb_we", int'(fb_we), 0);
        check("midrst_busy", int'(busy), 0);
        check("midrst_overflow", int'(overflow), 0);
        #2 rst = 1'b0;
        @(posedge clk);
        #1;
        wq.delete();
        for (int k = 0; k < 5; k++) step(0, 2'd0, 8'd0, 0);
        check("postrst_no_writes", wq.size(), 0);
        check("postrst_busy", int'(busy), 0);
        // Y shadow was cleared by reset, so this PLOT lands on row 0.
        step(1, 2'd0, 8'd3, 0);
        step(1, 2'd2, 8'd6, 0);
        step(1, 2'd3, 8'h00, 0);
        drain(10, 0);
        check("postrst_plot_count", wq.size(), 1);
        if (wq.size() > 0) check("postrst_plot_pixel", int'(wq[0]), int'({8'd3, 8'd0, 3'd6}));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
